uart_rx_frame: RTL and testbench

//  Oversampling UART receiver; downstream counterpart of the UART transmitter on the serial link.

---
 rtl/uart_rx_frame.sv | 97 +++++++++
 tb/tb_uart_rx_frame.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_frame.sv
// uart_rx_frame: oversampling UART receiver (start, data LSB-first, optional parity, stop); define UART_RX_DEGLITCH_EN for 3-sample majority vote
module uart_rx_frame #(
   parameter int width = 8
) (
   input  logic             CLK,
   input  logic             Reset,
   input  logic             RX_IN,
   input  logic [5:0]       Prescale,
   input  logic             Parity_EN,
   input  logic             Parity_type,
   output logic [width-1:0] Data_out,
   output logic             Data_valid,
   output logic             Parity_error,
   output logic             Stop_error,
   output logic             Rx_busy
);
   localparam int BW = (width > 1) ? $clog2(width) : 1;
   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
   state_t state, state_n;
   logic [5:0] p_lat, edge_cnt, half;
   logic [BW-1:0] bit_cnt;
   logic [width-1:0] shreg;
   logic err, armed, bit_val, samp, last_edge, dv_n, pe_n, se_n;
   assign half = {1'b0, p_lat[5:1]};
   assign last_edge = edge_cnt == p_lat - 6'd1;
`ifdef UART_RX_DEGLITCH_EN
   logic [1:0] smp;
   assign samp = edge_cnt == half + 6'd1;
   assign bit_val = (smp[0] & smp[1]) | (smp[0] & RX_IN) | (smp[1] & RX_IN);
   // capture the two samples preceding the decision point
   always_ff @(posedge CLK or negedge Reset)
      if (!Reset) smp <= '0;
      else begin
         if (edge_cnt == half - 6'd1) smp[0] <= RX_IN;
         if (edge_cnt == half) smp[1] <= RX_IN;
      end
`else
   assign samp = edge_cnt == half;
   assign bit_val = RX_IN;
`endif
   // state register
   always_ff @(posedge CLK or negedge Reset)
      if (!Reset) state <= IDLE;
      else state <= state_n;
   // next-state and strobe decode
   always_comb begin
      state_n = state;
      dv_n = 1'b0;
      pe_n = 1'b0;
      se_n = 1'b0;
      case (state)
         IDLE:   if (armed && !RX_IN) state_n = START;
         START:  if (samp && bit_val) state_n = IDLE;
                 else if (last_edge) state_n = DATA;
         DATA:   if (last_edge && bit_cnt == BW'(width - 1)) state_n = Parity_EN ? PARITY : STOP;
         PARITY: if (last_edge) state_n = STOP;
         STOP:   if (samp) begin
                    state_n = IDLE;
                    dv_n = bit_val & ~err;
                    pe_n = err;
                    se_n = ~bit_val;
                 end
         default: state_n = IDLE;
      endcase
   end
   // counters, shift register, error flag, arming and registered outputs
   always_ff @(posedge CLK or negedge Reset)
      if (!Reset) begin
         p_lat <= 6'd16;
         edge_cnt <= '0;
         bit_cnt <= '0;
         shreg <= '0;
         err <= 1'b0;
         armed <= 1'b0;
         Data_out <= '0;
         Data_valid <= 1'b0;
         Parity_error <= 1'b0;
         Stop_error <= 1'b0;
         Rx_busy <= 1'b0;
      end else begin
         Data_valid <= dv_n;
         Parity_error <= pe_n;
         Stop_error <= se_n;
         Rx_busy <= state_n != IDLE;
         if (dv_n) Data_out <= shreg;
         armed <= se_n ? 1'b0 : (armed | RX_IN);
         edge_cnt <= (state == IDLE || last_edge) ? 6'd0 : edge_cnt + 6'd1;
         if (state == IDLE) begin
            p_lat <= Prescale;
            bit_cnt <= '0;
            err <= 1'b0;
         end
         if (state == DATA && last_edge) bit_cnt <= bit_cnt + 1'b1;
         if (state == DATA && samp) shreg <= {bit_val, shreg[width-1:1]};
         if (state == PARITY && samp) err <= err | (bit_val != ((^shreg) ^ Parity_type));
      end
endmodule

// File: tb/tb_uart_rx_frame.sv
// tb_uart_rx_frame: randomized and directed checks of uart_rx_frame against a frame-level reference model
module tb_uart_rx_frame;
`ifdef UART_RX_DEGLITCH_EN
   localparam int DG = 1;
`else
   localparam int DG = 0;
`endif
   typedef struct {
      int         cyc;
      logic [2:0] kind;
      logic [7:0] data;
   } ev_t;
   logic CLK = 1'b0, Reset, RX_IN, Parity_EN, Parity_type;
   logic [5:0] Prescale;
   logic [7:0] Data_out;
   logic Data_valid, Parity_error, Stop_error, Rx_busy;
   int cyc = 0, n_chk = 0, n_err = 0;
   logic [7:0] exp_dout;
   ev_t act_q[$], exp_q[$];
   uart_rx_frame #(.width(8)) dut (
      .CLK(CLK), .Reset(Reset), .RX_IN(RX_IN), .Prescale(Prescale),
      .Parity_EN(Parity_EN), .Parity_type(Parity_type), .Data_out(Data_out),
      .Data_valid(Data_valid), .Parity_error(Parity_error), .Stop_error(Stop_error),
      .Rx_busy(Rx_busy)
   );
   always #5 CLK = ~CLK;
   always @(posedge CLK) cyc <= cyc + 1;
   // record every strobe cycle with the edge that produced it
   always @(negedge CLK) begin
      ev_t e;
      if (Reset && (Data_valid || Parity_error || Stop_error)) begin
         e.cyc = cyc;
         e.kind = {Data_valid, Parity_error, Stop_error};
         e.data = Data_out;
         act_q.push_back(e);
      end
   end
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask
   // frame-level model: outcome and strobe edge from the line-level rules
   task automatic expect_frame(input int st, input int p, input logic pe, input logic [7:0] d,
                               input logic bad, input logic stb);
      ev_t e;
      logic pbad;
      pbad = pe & bad;
      if (stb && !pbad) exp_dout = d;
      e.cyc = st + (9 + int'(pe)) * p + p / 2 + 1 + DG;
      e.kind = {stb & ~pbad, pbad, ~stb};
      e.data = exp_dout;
      exp_q.push_back(e);
   endtask
   // drive one frame; entered and left 1 time unit after a rising edge
   task automatic send_frame(input logic [7:0] d, input int p, input logic pe, input logic pt,
                             input logic bad, input logic stb);
      logic [10:0] bits;
      int n;
      Prescale = 6'(p);
      Parity_EN = pe;
      Parity_type = pt;
      expect_frame(cyc + 1, p, pe, d, bad, stb);
      bits = pe ? {stb, (^d) ^ pt ^ bad, d, 1'b0} : {1'b1, stb, d, 1'b0};
      n = pe ? 11 : 10;
      for (int i = 0; i < n; i++) begin
         RX_IN = bits[i];
         if (i == 1) Prescale = 6'(8 << $urandom_range(0, 2));
         if (i == 2) chk("busy_mid", Rx_busy, 1);
         repeat (p) @(posedge CLK);
         #1;
      end
   endtask
   task automatic compare_events(input string tag);
      int n;
      chk({tag, "_count"}, act_q.size(), exp_q.size());
      n = act_q.size() < exp_q.size() ? act_q.size() : exp_q.size();
      for (int i = 0; i < n; i++) begin
         chk({tag, "_cyc"}, act_q[i].cyc, exp_q[i].cyc);
         chk({tag, "_kind"}, act_q[i].kind, exp_q[i].kind);
         chk({tag, "_data"}, act_q[i].data, exp_q[i].data);
      end
      act_q.delete();
      exp_q.delete();
   endtask
   task automatic idle(input int n);
      RX_IN = 1'b1;
      repeat (n) @(posedge CLK);
      #1;
   endtask
   initial begin
      Reset = 1'b0;
      RX_IN = 1'b1;
      Prescale = 6'd16;
      Parity_EN = 1'b0;
      Parity_type = 1'b0;
      exp_dout = 8'h00;
      repeat (3) @(posedge CLK);
      #1;
      chk("rst_dout", Data_out, 0);
      chk("rst_dv", Data_valid, 0);
      chk("rst_pe", Parity_error, 0);
      chk("rst_se", Stop_error, 0);
      chk("rst_busy", Rx_busy, 0);
      Reset = 1'b1;
      idle(2);
      send_frame(8'hA5, 8, 1'b0, 1'b0, 1'b0, 1'b1);
      idle(4);
      compare_events("t1");
      chk("t1_dout", Data_out, 8'hA5);
      send_frame(8'h3C, 16, 1'b1, 1'b0, 1'b1, 1'b1);
      idle(4);
      compare_events("t2");
      chk("t2_dout", Data_out, 8'hA5);
      send_frame(8'h55, 16, 1'b0, 1'b0, 1'b0, 1'b0);
      repeat (48) @(posedge CLK);
      #1;
      chk("t3_busy", Rx_busy, 0);
      compare_events("t3");
      idle(3);
      Prescale = 6'd16;
      RX_IN = 1'b0;
      repeat (3) @(posedge CLK);
      #1;
      chk("t4_busy_hi", Rx_busy, 1);
      idle(30);
      chk("t4_busy_lo", Rx_busy, 0);
      compare_events("t4");
      send_frame(8'h00, 32, 1'b1, 1'b1, 1'b0, 1'b1);
      send_frame(8'hFF, 32, 1'b1, 1'b1, 1'b0, 1'b1);
      idle(4);
      compare_events("t5");
      Prescale = 6'd16;
      Parity_EN = 1'b0;
      RX_IN = 1'b0;
      repeat (16) @(posedge CLK);
      RX_IN = 1'b1;
      repeat (16) @(posedge CLK);
      RX_IN = 1'b0;
      repeat (48) @(posedge CLK);
      RX_IN = 1'b1;
      repeat (8) @(posedge CLK);
      #1;
      Reset = 1'b0;
      #1;
      chk("t6_dout", Data_out, 0);
      chk("t6_dv", Data_valid, 0);
      chk("t6_pe", Parity_error, 0);
      chk("t6_se", Stop_error, 0);
      chk("t6_busy", Rx_busy, 0);
      exp_dout = 8'h00;
      RX_IN = 1'b0;
      repeat (3) @(posedge CLK);
      #1;
      Reset = 1'b1;
      repeat (48) @(posedge CLK);
      #1;
      chk("t6_hold_busy", Rx_busy, 0);
      compare_events("t6_hold");
      idle(3);
      send_frame(8'h81, 16, 1'b0, 1'b0, 1'b0, 1'b1);
      idle(4);
      compare_events("t6");
      chk("t6_dout_new", Data_out, 8'h81);
      for (int k = 0; k < 24; k++) begin
         logic stb;
         stb = ($urandom_range(0, 4) != 0);
         send_frame(8'($urandom), 8 << $urandom_range(0, 2), 1'($urandom), 1'($urandom),
                    $urandom_range(0, 3) == 0, stb);
         idle(stb ? $urandom_range(0, 3) : $urandom_range(1, 3));
      end
      idle(8);
      compare_events("rnd");
      chk("rnd_dout", Data_out, exp_dout);
      chk("end_busy", Rx_busy, 0);
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
